// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared types, register map and bounce helpers for the ball motion engine
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CALC    = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] vel;
    } axis_t;

    localparam logic [2:0] ADDR_VEL_X  = 3'd0;
    localparam logic [2:0] ADDR_VEL_Y  = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_INIT_X = 3'd3;
    localparam logic [2:0] ADDR_INIT_Y = 3'd4;
    localparam logic [2:0] ADDR_DIV    = 3'd5;

    localparam logic [7:0] RST_BALL_X = 8'd3;
    localparam logic [7:0] RST_BALL_Y = 8'd3;
    localparam logic [7:0] RST_VEL_X  = 8'd1;
    localparam logic [7:0] RST_VEL_Y  = 8'd1;

    // Two's-complement negate with -128 pinned to +127 so the sign always flips.
    function automatic logic [7:0] neg_sat(input logic [7:0] v);
        return (v == 8'h80) ? 8'h7f : (~v + 8'd1);
    endfunction

    function automatic axis_t bounce(input logic signed [9:0] n,
                                     input logic [7:0]        vel,
                                     input logic [7:0]        max_pos);
        axis_t r;
        r.pos = n[7:0];
        r.vel = vel;
        if (n[9]) begin
            r.pos = 8'd0;
            r.vel = neg_sat(vel);
        end else if (n > $signed({2'b00, max_pos})) begin
            r.pos = max_pos;
            r.vel = neg_sat(vel);
        end
        return r;
    endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// rtl/vs_edge_detect.sv - registers vertical sync and flags its falling edge
module vs_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic vs,
    output logic vs_fall
);

    logic vs_prev;

    // Sync idles high, so resetting to 1 avoids a false edge out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev <= 1'b1;
        end else begin
            vs_prev <= vs;
        end
    end

    assign vs_fall = vs_prev & ~vs;

endmodule

// File: rtl/ball_motion_engine.sv
// rtl/ball_motion_engine.sv - frame-synchronous ball position generator with edge bounce
module ball_motion_engine
    import ball_pkg::*;
#(
    parameter int BALL_W  = 64,
    parameter int BALL_H  = 64,
    parameter int X_LIMIT = 160,
    parameter int Y_LIMIT = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       chipselect,
    input  logic       write,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    input  logic       vga_vs,
    output logic [7:0] ball_x,
    output logic [7:0] ball_y,
    output logic       update_pulse
);

    localparam logic [7:0] X_MAX = 8'(X_LIMIT - BALL_W);
    localparam logic [7:0] Y_MAX = 8'(Y_LIMIT - BALL_H);

    state_t            state, state_next;
    logic [7:0]        vel_x, vel_y;
    logic [7:0]        init_x, init_y;
    logic [7:0]        div, frame_cnt;
    logic              enable, load_pend, commit_load;
    logic signed [9:0] nx, ny;
    logic              vs_fall, tick, wr;
    axis_t             bx, by;

    vs_edge_detect u_vs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .vs      (vga_vs),
        .vs_fall (vs_fall)
    );

    assign wr   = chipselect & write;
    assign tick = vs_fall && (frame_cnt == div);
    assign bx   = bounce(nx, vel_x, X_MAX);
    assign by   = bounce(ny, vel_y, Y_MAX);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (enable || load_pend) state_next = WAIT_VS;
            WAIT_VS: begin
                if (!enable && !load_pend) state_next = IDLE;
                else if (tick)             state_next = load_pend ? COMMIT : CALC;
            end
            CALC:    state_next = COMMIT;
            COMMIT:  state_next = WAIT_VS;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ball_x       <= RST_BALL_X;
            ball_y       <= RST_BALL_Y;
            vel_x        <= RST_VEL_X;
            vel_y        <= RST_VEL_Y;
            init_x       <= 8'd0;
            init_y       <= 8'd0;
            div          <= 8'd0;
            frame_cnt    <= 8'd0;
            enable       <= 1'b0;
            load_pend    <= 1'b0;
            commit_load  <= 1'b0;
            nx           <= '0;
            ny           <= '0;
            update_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            update_pulse <= (state == COMMIT);

            if (wr && address == ADDR_DIV) begin
                frame_cnt <= 8'd0;
            end else if (vs_fall) begin
                frame_cnt <= (frame_cnt == div) ? 8'd0 : frame_cnt + 8'd1;
            end

            if (wr && address == ADDR_DIV)    div    <= writedata;
            if (wr && address == ADDR_INIT_X) init_x <= writedata;
            if (wr && address == ADDR_INIT_Y) init_y <= writedata;
            if (wr && address == ADDR_CTRL)   enable <= writedata[0];

            // Latched on leaving WAIT_VS; a load request arriving during CALC waits a frame.
            if (state == WAIT_VS) commit_load <= load_pend;

            if (wr && address == ADDR_CTRL && writedata[1]) begin
                load_pend <= 1'b1;
            end else if (state == COMMIT && commit_load) begin
                load_pend <= 1'b0;
            end

            if (state == CALC) begin
                nx <= $signed({2'b00, ball_x}) + $signed({{2{vel_x[7]}}, vel_x});
                ny <= $signed({2'b00, ball_y}) + $signed({{2{vel_y[7]}}, vel_y});
            end

            if (state == COMMIT) begin
                if (commit_load) begin
                    ball_x <= (init_x > X_MAX) ? X_MAX : init_x;
                    ball_y <= (init_y > Y_MAX) ? Y_MAX : init_y;
                end else begin
                    ball_x <= bx.pos;
                    ball_y <= by.pos;
                end
            end

            // A bus write to a velocity register overrides the bounce negation.
            if (wr && address == ADDR_VEL_X) begin
                vel_x <= writedata;
            end else if (state == COMMIT && !commit_load) begin
                vel_x <= bx.vel;
            end

            if (wr && address == ADDR_VEL_Y) begin
                vel_y <= writedata;
            end else if (state == COMMIT && !commit_load) begin
                vel_y <= by.vel;
            end
        end
    end

endmodule

// File: tb/tb_ball_motion_engine.sv
// tb/tb_ball_motion_engine.sv - directed self-checking bench for ball_motion_engine
module tb_ball_motion_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       chipselect;
    logic       write;
    logic [2:0] address;
    logic [7:0] writedata;
    logic       vga_vs;
    logic [7:0] ball_x;
    logic [7:0] ball_y;
    logic       update_pulse;

    int errors = 0;
    int checks = 0;

    ball_motion_engine dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .chipselect   (chipselect),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .vga_vs       (vga_vs),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .update_pulse (update_pulse)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    // One vertical-sync fall; exp_edge is the clock edge (1..6) after the fall at which
    // update_pulse must appear, 0 for none. wr_edge>0 drives a bus write after that edge.
    task automatic frame(input string tag, input int exp_edge,
                         input logic [7:0] ex, input logic [7:0] ey,
                         input int wr_edge, input logic [2:0] wa, input logic [7:0] wd);
        int pulses;
        int first;
        pulses = 0;
        first  = 0;
        @(negedge clk);
        vga_vs = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (chipselect) begin
                chipselect = 1'b0;
                write      = 1'b0;
            end
            if (update_pulse) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == wr_edge) begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = wa;
                writedata  = wd;
            end
            if (i == 2) vga_vs = 1'b1;
        end
        check({tag, " pulse_edge"}, first, exp_edge);
        check({tag, " pulse_count"}, pulses, (exp_edge != 0) ? 1 : 0);
        check({tag, " ball_x"}, ball_x, ex);
        check({tag, " ball_y"}, ball_y, ey);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = 8'd0;
        vga_vs     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ball_x", ball_x, 8'd3);
        check("reset ball_y", ball_y, 8'd3);
        check("reset pulse", update_pulse, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        frame("disabled", 0, 8'd3, 8'd3, 0, 3'd0, 8'd0);

        // 1: default velocity, every frame
        bus_write(3'd2, 8'h01);
        frame("t1 f1", 3, 8'd4, 8'd4, 0, 3'd0, 8'd0);
        frame("t1 f2", 3, 8'd5, 8'd5, 0, 3'd0, 8'd0);
        frame("t1 f3", 3, 8'd6, 8'd6, 0, 3'd0, 8'd0);

        // 2: load near right edge, then bounce
        bus_write(3'd3, 8'd95);
        bus_write(3'd2, 8'h03);
        frame("t2 load", 2, 8'd95, 8'd0, 0, 3'd0, 8'd0);
        bus_write(3'd0, 8'd4);
        frame("t2 bounce", 3, 8'd96, 8'd1, 0, 3'd0, 8'd0);
        frame("t2 after", 3, 8'd92, 8'd2, 0, 3'd0, 8'd0);
        frame("t2 step", 3, 8'd88, 8'd3, 0, 3'd0, 8'd0);

        // 3: -128 saturating negation at the top, then clamp at the bottom
        bus_write(3'd1, 8'h80);
        frame("t3 top", 3, 8'd84, 8'd0, 0, 3'd0, 8'd0);
        frame("t3 bottom", 3, 8'd80, 8'd56, 0, 3'd0, 8'd0);
        bus_write(3'd1, 8'd0);

        // 4: divider of 2, and restart of the count on a div write
        bus_write(3'd5, 8'd2);
        frame("t4 a", 0, 8'd80, 8'd56, 0, 3'd0, 8'd0);
        frame("t4 b", 0, 8'd80, 8'd56, 0, 3'd0, 8'd0);
        frame("t4 c", 3, 8'd76, 8'd56, 0, 3'd0, 8'd0);
        frame("t4 d", 0, 8'd76, 8'd56, 0, 3'd0, 8'd0);
        bus_write(3'd5, 8'd2);
        frame("t4 e", 0, 8'd76, 8'd56, 0, 3'd0, 8'd0);
        frame("t4 f", 0, 8'd76, 8'd56, 0, 3'd0, 8'd0);
        frame("t4 g", 3, 8'd72, 8'd56, 0, 3'd0, 8'd0);
        bus_write(3'd5, 8'd0);

        // 5: velocity write in the COMMIT cycle of a bounce wins
        bus_write(3'd2, 8'h03);
        frame("t5 load", 2, 8'd95, 8'd0, 0, 3'd0, 8'd0);
        bus_write(3'd0, 8'd4);
        frame("t5 bounce", 3, 8'd96, 8'd0, 2, 3'd0, 8'd2);
        frame("t5 kept", 3, 8'd96, 8'd0, 0, 3'd0, 8'd0);
        frame("t5 neg", 3, 8'd94, 8'd0, 0, 3'd0, 8'd0);

        // 6: reset during CALC
        @(negedge clk);
        vga_vs = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6 async ball_x", ball_x, 8'd3);
        check("t6 async ball_y", ball_y, 8'd3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("t6 pulse in reset", update_pulse, 1'b0);
        end
        vga_vs = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        frame("t6 idle", 0, 8'd3, 8'd3, 0, 3'd0, 8'd0);
        bus_write(3'd2, 8'h01);
        frame("t6 run", 3, 8'd4, 8'd4, 0, 3'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
